shift_reg_univ: RTL and testbench



---
 rtl/shift_reg_pkg.sv | 17 +
 rtl/shift_reg_univ_sat_counter.sv | 44 ++++
 rtl/shift_reg_univ.sv | 109 ++++++++++
 tb/tb_shift_reg_univ.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and widths.
package shift_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_SHR   = 3'd3,
        MODE_ROTL  = 3'd4,
        MODE_ROTR  = 3'd5,
        MODE_ASHR  = 3'd6,
        MODE_CLEAR = 3'd7
    } mode_t;

endpackage

// File: rtl/shift_reg_univ_sat_counter.sv
// Saturating up-counter with clear-to-zero and set-to-max controls.
// Reset parks the count at MAX so a freshly reset register reads as drained.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         clr,
    input  logic         setMax,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over set-max, which wins over a saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (setMax) begin
            cnt_d = MaxVal;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register: reset first, then the enable gates every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= MaxVal;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with clock enable, eight modes and a
// saturating shift counter that flags when a loaded word has been shifted out.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_r,
    input  logic              sin_l,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic              drained
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

    mode_t            modeSel;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shlBase;
    logic [WIDTH-1:0] shrBase;
    logic             cntInc;
    logic             cntClr;
    logic             cntSetMax;
    logic [CNT_W-1:0] cnt;

    assign modeSel = mode_t'(mode);

    // Shift bases are built with shift operators and then have their vacated
    // bit patched, so the same code stays legal when WIDTH is 1.
    assign shlBase = q_q << 1;
    assign shrBase = q_q >> 1;

    // Next-state data: one case on mode, defaulting to hold.
    always_comb begin
        q_d = q_q;
        unique case (modeSel)
            MODE_HOLD:  q_d = q_q;
            MODE_LOAD:  q_d = d;
            MODE_SHL: begin
                q_d    = shlBase;
                q_d[0] = sin_r;
            end
            MODE_SHR: begin
                q_d          = shrBase;
                q_d[WIDTH-1] = sin_l;
            end
            MODE_ROTL: begin
                q_d    = shlBase;
                q_d[0] = q_q[WIDTH-1];
            end
            MODE_ROTR: begin
                q_d          = shrBase;
                q_d[WIDTH-1] = q_q[0];
            end
            MODE_ASHR: begin
                q_d          = shrBase;
                q_d[WIDTH-1] = q_q[WIDTH-1];
            end
            MODE_CLEAR: q_d = '0;
            default:    q_d = q_q;
        endcase
    end

    // Counter controls: every shift or rotate counts, load restarts, clear drains.
    always_comb begin
        cntInc    = (modeSel == MODE_SHL)  || (modeSel == MODE_SHR) ||
                    (modeSel == MODE_ROTL) || (modeSel == MODE_ROTR) ||
                    (modeSel == MODE_ASHR);
        cntClr    = (modeSel == MODE_LOAD);
        cntSetMax = (modeSel == MODE_CLEAR);
    end

    // Data register: reset beats enable, enable beats mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en) begin
            q_q <= q_d;
        end
    end

    sat_counter #(
        .W   (CNT_W),
        .MAX (WIDTH)
    ) uCounter (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .inc    (cntInc),
        .clr    (cntClr),
        .setMax (cntSetMax),
        .cnt    (cnt)
    );

    assign q       = q_q;
    assign sout_l  = q_q[WIDTH-1];
    assign sout_r  = q_q[0];
    assign drained = (cnt == CntMax);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8, RST_VAL=8'hA5). Each step drives
// inputs, queues the expected register state, and checks it after the edge.
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    localparam int               W    = 8;
    localparam logic [W-1:0]     RVAL = 8'hA5;

    typedef struct {
        string        tag;
        logic [W-1:0] q;
        logic         drained;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [W-1:0]      d;
    logic              sin_r;
    logic              sin_l;
    logic [W-1:0]      q;
    logic              sout_l;
    logic              sout_r;
    logic              drained;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    shift_reg_univ #(
        .WIDTH   (W),
        .RST_VAL (RVAL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .d       (d),
        .sin_r   (sin_r),
        .sin_l   (sin_l),
        .q       (q),
        .sout_l  (sout_l),
        .sout_r  (sout_r),
        .drained (drained)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare every observable output.
    task automatic checkOutput();
        exp_t e;
        total++;
        assert (expQ.size() != 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard: observed=empty expected=entry");
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            total++;
            assert (q === e.q) else begin
                bad++;
                $error("[TB] FAIL %s q: observed=%h expected=%h", e.tag, q, e.q);
            end
            total++;
            assert (drained === e.drained) else begin
                bad++;
                $error("[TB] FAIL %s drained: observed=%b expected=%b", e.tag, drained, e.drained);
            end
            total++;
            assert (sout_l === e.q[W-1]) else begin
                bad++;
                $error("[TB] FAIL %s sout_l: observed=%b expected=%b", e.tag, sout_l, e.q[W-1]);
            end
            total++;
            assert (sout_r === e.q[0]) else begin
                bad++;
                $error("[TB] FAIL %s sout_r: observed=%b expected=%b", e.tag, sout_r, e.q[0]);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, then check it.
    task automatic applyStimulus(input string tag, input logic rstIn, input logic enIn,
                                 input mode_t m, input logic [W-1:0] dIn,
                                 input logic sr, input logic sl,
                                 input logic [W-1:0] expQv, input logic expDr);
        exp_t e;
        rst   = rstIn;
        en    = enIn;
        mode  = m;
        d     = dIn;
        sin_r = sr;
        sin_l = sl;
        e.tag     = tag;
        e.q       = expQv;
        e.drained = expDr;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [W-1:0] acc;
        rst = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; sin_r = 1'b0; sin_l = 1'b0;
        @(negedge clk);

        // Reset overrides an enabled LOAD.
        applyStimulus("reset", 1'b1, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b1);

        // Rotates.
        applyStimulus("load81", 1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
        applyStimulus("rotl",   1'b0, 1'b1, MODE_ROTL, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0);
        applyStimulus("rotr1",  1'b0, 1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0);
        applyStimulus("rotr2",  1'b0, 1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0);

        // Arithmetic and logical right shifts.
        applyStimulus("load80", 1'b0, 1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0);
        applyStimulus("ashr1",  1'b0, 1'b1, MODE_ASHR, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b0);
        applyStimulus("ashr2",  1'b0, 1'b1, MODE_ASHR, 8'h00, 1'b0, 1'b0, 8'hE0, 1'b0);
        applyStimulus("shr0",   1'b0, 1'b1, MODE_SHR,  8'h00, 1'b1, 1'b0, 8'h70, 1'b0);
        applyStimulus("shr1",   1'b0, 1'b1, MODE_SHR,  8'h00, 1'b0, 1'b1, 8'hB8, 1'b0);

        // Fill with ones through SHL; drained rises on the eighth shift and saturates.
        applyStimulus("load00", 1'b0, 1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        acc = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            acc = {acc[W-2:0], 1'b1};
            applyStimulus($sformatf("shl%0d", i), 1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0,
                          acc, (i >= 8) ? 1'b1 : 1'b0);
        end

        // Enable low freezes everything, even an otherwise valid LOAD.
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("enlow%0d", i), 1'b0, 1'b0, MODE_LOAD, 8'h3C, 1'b0, 1'b0,
                          8'hFF, 1'b1);
        end
        applyStimulus("enhigh", 1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0);
        applyStimulus("hold",   1'b0, 1'b1, MODE_HOLD, 8'hAA, 1'b1, 1'b1, 8'h3C, 1'b0);

        // Mid-sequence CLEAR.
        applyStimulus("loadF0a", 1'b0, 1'b1, MODE_LOAD,  8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0);
        applyStimulus("shlA1",   1'b0, 1'b1, MODE_SHL,   8'h00, 1'b0, 1'b0, 8'hE0, 1'b0);
        applyStimulus("shlA2",   1'b0, 1'b1, MODE_SHL,   8'h00, 1'b0, 1'b0, 8'hC0, 1'b0);
        applyStimulus("shlA3",   1'b0, 1'b1, MODE_SHL,   8'h00, 1'b0, 1'b0, 8'h80, 1'b0);
        applyStimulus("clear",   1'b0, 1'b1, MODE_CLEAR, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1);

        // Mid-sequence reset.
        applyStimulus("loadF0b", 1'b0, 1'b1, MODE_LOAD, 8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0);
        applyStimulus("shlB1",   1'b0, 1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0, 8'hE0, 1'b0);
        applyStimulus("shlB2",   1'b0, 1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b0);
        applyStimulus("shlB3",   1'b0, 1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0, 8'h80, 1'b0);
        applyStimulus("rstmid",  1'b1, 1'b1, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
